// File: rtl/utype_pkg.sv
// utype_pkg: shared opcodes, FSM state type, instruction field slices and
// the U-type immediate helper for the utype_core execution core.
package utype_pkg;

  localparam int INSTR_W  = 32;
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Instruction field slices: imm20 = [31:12], rd = [11:7], opcode = [6:0].
  localparam int IMM_MSB = 31;
  localparam int IMM_LSB = 12;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;
  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Sign-extended imm20<<12 at the widest supported XLEN; callers keep the
  // low XLEN bits, which is the correct sign extension for either width.
  function automatic logic signed [XLEN_MAX-1:0] sext_uimm(input logic [IMM_W-1:0] imm20);
    return $signed({{(XLEN_MAX-32){imm20[IMM_W-1]}}, imm20, 12'b0});
  endfunction

endpackage

// File: rtl/utype_if.sv
// utype_if: instruction-memory load port plus debug register read port.
// master = the host/bench side, slave = the core side.
interface utype_if
  import utype_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 6,
  parameter int RA_W    = 5
);
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [RA_W-1:0]    dbg_raddr;
  logic [XLEN-1:0]    dbg_rdata;

  modport master (output imem_we, imem_addr, imem_wdata, dbg_raddr, input dbg_rdata);
  modport slave  (input imem_we, imem_addr, imem_wdata, dbg_raddr, output dbg_rdata);
endinterface

// File: rtl/utype_regfile.sv
// utype_regfile: NREGS x XLEN register file, one synchronous write port,
// one combinational read port, register 0 hardwired to zero, async clear.
module utype_regfile
  import utype_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RA_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA_W-1:0] raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] regs [NREGS];

  // Write port; reset clears every entry so a restarted program sees zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0) ? '0 : regs[raddr];

endmodule

// File: rtl/utype_core.sv
// utype_core: self-contained LUI/AUIPC core with instruction memory, PC
// sequencer (IDLE/FETCH/EXEC/HALT), register file and debug read port.
// Two cycles per instruction: FETCH reads imem, EXEC decodes and writes back.
// Optional: define UTYPE_RETIRE_CNT_EN to add the saturating 'retired' output.
module utype_core
  import utype_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 64,
  parameter int              IMEM_AW    = $clog2(IMEM_DEPTH),
  parameter int              NREGS      = 32,
  parameter int              RA_W       = $clog2(NREGS),
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  utype_if.slave          bus,
  output logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal
`ifdef UTYPE_RETIRE_CNT_EN
  ,
  output logic [31:0]     retired
`endif
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("utype_core: RESET_PC must be word-aligned");
  end
  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("utype_core: XLEN must be 32 or 64");
  end

  state_t             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               illegal_q, illegal_d;
  logic               imem_wr;
  logic               fetch_en;
  logic               pc_oor;
  logic               rf_we;

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [INSTR_W-1:0] instr_p1;

  logic [6:0]             opcode_p1;
  logic [4:0]             rd_p1;
  logic signed [XLEN-1:0] uimm_p1;
  logic [XLEN-1:0]        result_p1;
  logic                   rd_ok_p1;

  // FETCH -> EXEC boundary: instruction word registered from imem
  assign pc_oor   = (pc_q >> 2) >= XLEN'(IMEM_DEPTH);
  assign fetch_en = (state_q == FETCH) && !pc_oor;

  // Instruction memory: load-port write in IDLE/HALT, synchronous fetch read.
  always_ff @(posedge clk) begin
    if (imem_wr) imem[bus.imem_addr] <= bus.imem_wdata;
    if (fetch_en) instr_p1 <= imem[pc_q[IMEM_AW+1:2]];
  end

  assign opcode_p1 = instr_p1[OPC_MSB:OPC_LSB];
  assign rd_p1     = instr_p1[RD_MSB:RD_LSB];
  assign uimm_p1   = XLEN'(sext_uimm(instr_p1[IMM_MSB:IMM_LSB]));
  assign result_p1 = (opcode_p1 == OP_LUI) ? $unsigned(uimm_p1) : pc_q + $unsigned(uimm_p1);
  assign rd_ok_p1  = (rd_p1 != 5'd0) && (int'(rd_p1) < NREGS);

  // Control state register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, PC update, writeback enable and load-port gating.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    illegal_d = illegal_q;
    imem_wr   = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      IDLE: begin
        imem_wr = bus.imem_we;
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (pc_oor) begin
          state_d   = HALT;
          illegal_d = 1'b0;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if ((opcode_p1 == OP_LUI) || (opcode_p1 == OP_AUIPC)) begin
          rf_we   = rd_ok_p1;
          pc_d    = pc_q + XLEN'(4);
          state_d = FETCH;
        end else begin
          // All-zero word is a clean stop; anything else is an illegal opcode.
          state_d   = HALT;
          illegal_d = (instr_p1 != '0);
        end
      end
      HALT: begin
        imem_wr = bus.imem_we;
        if (run) begin
          pc_d      = RESET_PC;
          illegal_d = 1'b0;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // EXEC -> regfile boundary: write lands at the end of EXEC
  utype_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .RA_W  (RA_W)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (rd_p1[RA_W-1:0]),
    .wdata (result_p1),
    .raddr (bus.dbg_raddr),
    .rdata (bus.dbg_rdata)
  );

  assign pc      = pc_q;
  assign busy    = (state_q == FETCH) || (state_q == EXEC);
  assign halted  = (state_q == HALT);
  assign illegal = illegal_q;

`ifdef UTYPE_RETIRE_CNT_EN
  logic        retire;
  logic [31:0] retired_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign retire = (state_q == EXEC) && ((opcode_p1 == OP_LUI) || (opcode_p1 == OP_AUIPC));

  // Retired-instruction counter, cleared on reset and on restart from HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if ((state_q == HALT) && run) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= sat_inc(retired_q);
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_utype_core.sv
// tb_utype_core: table-driven vectors, hand-written corner sequences and
// randomized programs checked against a program-level reference model.
module tb_utype_core;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  utype_if #(.XLEN(32), .IMEM_AW(6), .RA_W(5)) bus();
  logic [31:0] pc;
  logic        busy, halted, illegal;
`ifdef UTYPE_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  utype_core dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .bus     (bus),
    .pc      (pc),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal)
`ifdef UTYPE_RETIRE_CNT_EN
    ,
    .retired (retired)
`endif
  );

  // 64-bit, 4-word instance for sign extension and imem-end boundary
  logic run64 = 1'b0;
  utype_if #(.XLEN(64), .IMEM_AW(2), .RA_W(5)) bus64();
  logic [63:0] pc64;
  logic        busy64, halted64, illegal64;
`ifdef UTYPE_RETIRE_CNT_EN
  logic [31:0] retired64;
`endif

  utype_core #(.XLEN(64), .IMEM_DEPTH(4)) dut64 (
    .clk     (clk),
    .reset   (reset),
    .run     (run64),
    .bus     (bus64),
    .pc      (pc64),
    .busy    (busy64),
    .halted  (halted64),
    .illegal (illegal64)
`ifdef UTYPE_RETIRE_CNT_EN
    ,
    .retired (retired64)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load(input int addr, input logic [31:0] word);
    bus.imem_we    = 1'b1;
    bus.imem_addr  = 6'(addr);
    bus.imem_wdata = word;
    @(negedge clk);
    bus.imem_we    = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("halt_reached", {63'd0, halted}, 64'd1);
  endtask

  task automatic run_wait(output int cyc);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_halt(cyc);
  endtask

  task automatic rreg(input int idx, output logic [31:0] v);
    bus.dbg_raddr = 5'(idx);
    #1;
    v = bus.dbg_rdata;
  endtask

  task automatic rreg64(input int idx, output logic [63:0] v);
    bus64.dbg_raddr = 5'(idx);
    #1;
    v = bus64.dbg_rdata;
  endtask

  // Reference model: executes the program word by word from the ISA rules.
  logic [31:0] prog [DEPTH];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_ill;
  int          m_cyc;
  int          m_ret;

  task automatic model_run();
    bit          done;
    logic [31:0] ins;
    logic [31:0] imm;
    int          rd;
    done = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc = '0; m_ill = 1'b0; m_cyc = 0; m_ret = 0;
    while (!done) begin
      if (m_pc / 4 >= DEPTH) begin
        m_cyc += 1;
        done = 1'b1;
      end else begin
        ins = prog[m_pc / 4];
        imm = {ins[31:12], 12'h000};
        rd  = int'(ins[11:7]);
        m_cyc += 2;
        if (ins[6:0] == 7'h37) begin
          if (rd != 0) m_regs[rd] = imm;
          m_pc += 4; m_ret++;
        end else if (ins[6:0] == 7'h17) begin
          if (rd != 0) m_regs[rd] = m_pc + imm;
          m_pc += 4; m_ret++;
        end else begin
          m_ill = (ins != 32'h0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_model(input string tag, input int cyc);
    logic [31:0] v;
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_illegal"}, {63'd0, illegal}, {63'd0, m_ill});
    check({tag, "_cycles"}, 64'(cyc), 64'(m_cyc));
    for (int r = 0; r < 32; r++) begin
      rreg(r, v);
      check($sformatf("%s_x%0d", tag, r), v, m_regs[r]);
    end
`ifdef UTYPE_RETIRE_CNT_EN
    check({tag, "_retired"}, retired, 64'(m_ret));
`endif
  endtask

  typedef struct {
    logic [31:0] instr;
    int          reg_idx;
    logic [31:0] reg_val;
    logic [31:0] exp_pc;
    logic        exp_ill;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int          cyc;
    int          len;
    logic [31:0] v;
    logic [63:0] v64;
    logic [31:0] w;

    bus.imem_we = 1'b0; bus.imem_addr = '0; bus.imem_wdata = '0; bus.dbg_raddr = '0;
    bus64.imem_we = 1'b0; bus64.imem_addr = '0; bus64.imem_wdata = '0; bus64.dbg_raddr = '0;

    vecs[0] = '{32'h123450B7, 1,  32'h12345000, 32'd4, 1'b0, 4};
    vecs[1] = '{32'hFFFFF037, 0,  32'h00000000, 32'd4, 1'b0, 4};
    vecs[2] = '{32'h00001117, 2,  32'h00001000, 32'd4, 1'b0, 4};
    vecs[3] = '{32'h800001B7, 3,  32'h80000000, 32'd4, 1'b0, 4};
    vecs[4] = '{32'h00000013, 1,  32'h00000000, 32'd0, 1'b1, 2};
    vecs[5] = '{32'h00000000, 1,  32'h00000000, 32'd0, 1'b0, 2};
    vecs[6] = '{32'hFFFFFFB7, 31, 32'hFFFFF000, 32'd4, 1'b0, 4};
    vecs[7] = '{32'hFFFFFF97, 31, 32'hFFFFF000, 32'd4, 1'b0, 4};
    vecs[8] = '{32'h0000007F, 31, 32'h00000000, 32'd0, 1'b1, 2};
    vecs[9] = '{32'h00000017, 0,  32'h00000000, 32'd4, 1'b0, 4};

    // Reset state, sampled while reset is held low
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);
    check("rst_pc", pc, 64'd0);
    rreg(1, v);
    check("rst_x1", v, 64'd0);
`ifdef UTYPE_RETIRE_CNT_EN
    check("rst_retired", retired, 64'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    // 64-bit instance: sign extension, AUIPC wrap, halt past imem end
    bus64.imem_we = 1'b1;
    bus64.imem_addr = 2'd0; bus64.imem_wdata = 32'h800001B7; @(negedge clk);
    bus64.imem_addr = 2'd1; bus64.imem_wdata = 32'hFFFFF217; @(negedge clk);
    bus64.imem_addr = 2'd2; bus64.imem_wdata = 32'h7FFFF2B7; @(negedge clk);
    bus64.imem_addr = 2'd3; bus64.imem_wdata = 32'h00001337; @(negedge clk);
    bus64.imem_we = 1'b0;
    run64 = 1'b1;
    @(negedge clk);
    run64 = 1'b0;
    cyc = 0;
    while (!halted64 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("x64_halted", {63'd0, halted64}, 64'd1);
    check("x64_cycles", 64'(cyc), 64'd9);
    check("x64_pc", pc64, 64'd16);
    check("x64_illegal", {63'd0, illegal64}, 64'd0);
    rreg64(3, v64); check("x64_x3", v64, 64'hFFFFFFFF80000000);
    rreg64(4, v64); check("x64_x4", v64, 64'hFFFFFFFFFFFFF004);
    rreg64(5, v64); check("x64_x5", v64, 64'h000000007FFFF000);
    rreg64(6, v64); check("x64_x6", v64, 64'h0000000000001000);
`ifdef UTYPE_RETIRE_CNT_EN
    check("x64_retired", retired64, 64'd4);
`endif

    // Single-instruction vectors, each followed by a zero halt word
    for (int i = 0; i < 10; i++) begin
      do_reset();
      load(0, vecs[i].instr);
      load(1, 32'h0);
      run_wait(cyc);
      check($sformatf("vec%0d_illegal", i), {63'd0, illegal}, {63'd0, vecs[i].exp_ill});
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
      rreg(vecs[i].reg_idx, v);
      check($sformatf("vec%0d_reg", i), v, vecs[i].reg_val);
    end

    // LUI to x0 then AUIPC at pc=4
    do_reset();
    load(0, 32'hFFFFF037);
    load(1, 32'h00001117);
    load(2, 32'h0);
    run_wait(cyc);
    rreg(0, v); check("seqa_x0", v, 64'd0);
    rreg(2, v); check("seqa_x2", v, 64'h00001004);
    check("seqa_pc", pc, 64'd8);
`ifdef UTYPE_RETIRE_CNT_EN
    check("seqa_retired", retired, 64'd2);
`endif

    // Illegal opcode after a good program; load in HALT; restart twice
    do_reset();
    load(0, 32'h123450B7);
    load(1, 32'h0);
    run_wait(cyc);
    load(0, 32'h00000013);
    run_wait(cyc);
    check("ill1_illegal", {63'd0, illegal}, 64'd1);
    check("ill1_pc", pc, 64'd0);
    rreg(1, v); check("ill1_x1_kept", v, 64'h12345000);
`ifdef UTYPE_RETIRE_CNT_EN
    check("ill1_retired", retired, 64'd0);
`endif
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("ill2_cleared", {63'd0, illegal}, 64'd0);
    check("ill2_busy", {63'd0, busy}, 64'd1);
    wait_halt(cyc);
    check("ill2_illegal", {63'd0, illegal}, 64'd1);
    check("ill2_pc", pc, 64'd0);

    // Load and run in the same IDLE cycle: first fetch sees the new word
    do_reset();
    load(1, 32'h0);
    bus.imem_we = 1'b1; bus.imem_addr = 6'd0; bus.imem_wdata = 32'hABCDE337;
    run = 1'b1;
    @(negedge clk);
    bus.imem_we = 1'b0; run = 1'b0;
    wait_halt(cyc);
    rreg(6, v); check("wr_run_x6", v, 64'hABCDE000);
    check("wr_run_pc", pc, 64'd4);

    // Load port and run are ignored while busy
    do_reset();
    load(0, 32'h111110B7);
    load(1, 32'h0);
    run = 1'b1;
    @(negedge clk);
    bus.imem_we = 1'b1; bus.imem_addr = 6'd1; bus.imem_wdata = 32'h777773B7;
    @(negedge clk);
    bus.imem_we = 1'b0; run = 1'b0;
    wait_halt(cyc);
    rreg(7, v); check("busy_we_x7", v, 64'd0);
    rreg(1, v); check("busy_we_x1", v, 64'h11111000);
    check("busy_we_pc", pc, 64'd4);
    check("busy_we_illegal", {63'd0, illegal}, 64'd0);

    // Reset asserted during EXEC of LUI x5 aborts with no writeback
    do_reset();
    load(0, 32'h123452B7);
    load(1, 32'h0);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("abort_in_exec_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    rreg(5, v); check("abort_x5", v, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_halted", {63'd0, halted}, 64'd0);
    check("abort_pc", pc, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    run_wait(cyc);
    rreg(5, v); check("rerun_x5", v, 64'h12345000);
    check("rerun_pc", pc, 64'd4);
    check("rerun_cycles", 64'(cyc), 64'd4);

    // Fill every imem word with U-type ops: runs off the end of imem
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      prog[i] = {20'($urandom), 5'((i % 31) + 1), ((i % 2) == 0) ? 7'h37 : 7'h17};
      load(i, prog[i]);
    end
    model_run();
    run_wait(cyc);
    compare_model("full", cyc);
    check("full_pc_end", pc, 64'd256);

    // Randomized programs against the reference model
    for (int t = 0; t < 25; t++) begin
      do_reset();
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        prog[i] = {20'($urandom), 5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
      end
      if ($urandom_range(0, 2) == 0) begin
        w = 32'h0;
      end else begin
        do w = $urandom; while ((w[6:0] == 7'h37) || (w[6:0] == 7'h17));
      end
      prog[len] = w;
      for (int i = 0; i <= len; i++) load(i, prog[i]);
      model_run();
      run_wait(cyc);
      compare_model($sformatf("rnd%0d", t), cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
